// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, line encodings, key matrix map
// and emulator states. Used by the scanner and the emulator.
package keypad_pkg;

  localparam logic [3:0] KEY_HASH = 4'd10;
  localparam logic [3:0] KEY_STAR = 4'd11;
  localparam logic [3:0] KEY_A    = 4'd12;
  localparam logic [3:0] KEY_B    = 4'd13;
  localparam logic [3:0] KEY_C    = 4'd14;
  localparam logic [3:0] KEY_D    = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BOUNCE_IN,
    ST_HOLD,
    ST_BOUNCE_OUT,
    ST_GAP
  } emu_state_e;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] c;
  } key_rc_t;

  // Line 0 sits on bit 3 for both rows and columns
  function automatic logic [3:0] line_onehot_n(
    input logic [1:0] idx
  );
    return ~(4'b1000 >> idx);
  endfunction

  function automatic key_rc_t key_to_rc(
    input logic [3:0] key
  );
    key_rc_t rc;
    unique case (key)
      4'd1:     rc = '{2'd0, 2'd0};
      4'd2:     rc = '{2'd0, 2'd1};
      4'd3:     rc = '{2'd0, 2'd2};
      KEY_A:    rc = '{2'd0, 2'd3};
      4'd4:     rc = '{2'd1, 2'd0};
      4'd5:     rc = '{2'd1, 2'd1};
      4'd6:     rc = '{2'd1, 2'd2};
      KEY_B:    rc = '{2'd1, 2'd3};
      4'd7:     rc = '{2'd2, 2'd0};
      4'd8:     rc = '{2'd2, 2'd1};
      4'd9:     rc = '{2'd2, 2'd2};
      KEY_C:    rc = '{2'd2, 2'd3};
      KEY_STAR: rc = '{2'd3, 2'd0};
      4'd0:     rc = '{2'd3, 2'd1};
      KEY_HASH: rc = '{2'd3, 2'd2};
      KEY_D:    rc = '{2'd3, 2'd3};
      default:  rc = '{2'd0, 2'd0};
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Command handshake bundle for keypad_emulator.
// master drives the command, slave returns ready.
interface keypad_emulator_if #(
  parameter int HOLD_W = 24
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_key;
  logic [HOLD_W-1:0] cmd_hold;

  modport master (
    output cmd_valid,
    output cmd_key,
    output cmd_hold,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_key,
    input  cmd_hold,
    output cmd_ready
  );

endinterface

// File: rtl/keypad_lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, with enable.
// SEED must be nonzero.
module keypad_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  output logic [7:0] o_q
);

  logic [7:0] r_q;
  logic       w_fb;

  assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];
  assign o_q  = r_q;

  always_ff @(posedge clk) begin
    if (rst)       r_q <= SEED;
    else if (i_en) r_q <= {r_q[6:0], w_fb};
  end

endmodule

// File: rtl/keypad_emulator.sv
// Keypad responder: presses one matrix key per command.
// Define KEYPAD_EMU_BOUNCE_EN to add LFSR contact bounce.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int         HOLD_W        = 24,
  parameter int         GAP_CYCLES    = 16,
  parameter int         BOUNCE_CYCLES = 64,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        col,
  output logic [3:0]        row,
  keypad_emulator_if.slave  cmd,
  output logic              busy,
  output logic              done
);

  localparam logic [HOLD_W-1:0] GAP_LD =
    HOLD_W'(GAP_CYCLES - 1);
  localparam logic GAP_ONE = (GAP_CYCLES == 1);

  emu_state_e        r_state;
  logic [HOLD_W-1:0] r_cnt;
  logic [3:0]        r_key;
  logic              r_done;
  logic [HOLD_W-1:0] w_hold_ld;
  logic              w_bounce;
  logic              w_contact;
  logic              w_hit;
  key_rc_t           w_rc;

  assign w_hold_ld = (cmd.cmd_hold == '0) ?
    '0 : cmd.cmd_hold - HOLD_W'(1);

  assign w_bounce = (r_state == ST_BOUNCE_IN) ||
                    (r_state == ST_BOUNCE_OUT);

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [HOLD_W-1:0] BNC_LD =
    HOLD_W'(BOUNCE_CYCLES - 1);

  logic [HOLD_W-1:0] r_hold;
  logic [7:0]        w_lfsr_q;
  logic              w_unused_lfsr;

  assign w_unused_lfsr = ^w_lfsr_q[7:1];

  keypad_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_bounce),
    .o_q  (w_lfsr_q)
  );

  assign w_contact = (r_state == ST_HOLD) ||
                     (w_bounce && w_lfsr_q[0]);
`else
  logic w_unused_cfg;

  assign w_unused_cfg = w_bounce ^ (^LFSR_SEED) ^
                        (BOUNCE_CYCLES != 0);
  assign w_contact    = (r_state == ST_HOLD);
`endif

  // Wired matrix: the row follows col with no register in between
  assign w_rc  = key_to_rc(r_key);
  assign w_hit = (col | line_onehot_n(w_rc.c)) != 4'hF;
  assign row   = (w_contact && w_hit) ?
    line_onehot_n(w_rc.r) : 4'hF;

  assign cmd.cmd_ready = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_key   <= '0;
      r_done  <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      r_hold  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (cmd.cmd_valid) begin
            r_key <= cmd.cmd_key;
`ifdef KEYPAD_EMU_BOUNCE_EN
            r_hold  <= w_hold_ld;
            r_cnt   <= BNC_LD;
            r_state <= ST_BOUNCE_IN;
`else
            r_cnt   <= w_hold_ld;
            r_state <= ST_HOLD;
`endif
          end
        end
        ST_BOUNCE_IN: begin
`ifdef KEYPAD_EMU_BOUNCE_EN
          if (r_cnt == '0) begin
            r_cnt   <= r_hold;
            r_state <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt - HOLD_W'(1);
          end
`else
          r_state <= ST_IDLE;
`endif
        end
        ST_HOLD: begin
          if (r_cnt == '0) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
            r_cnt   <= BNC_LD;
            r_state <= ST_BOUNCE_OUT;
`else
            r_cnt   <= GAP_LD;
            r_done  <= GAP_ONE;
            r_state <= ST_GAP;
`endif
          end else begin
            r_cnt <= r_cnt - HOLD_W'(1);
          end
        end
        ST_BOUNCE_OUT: begin
          if (r_cnt == '0) begin
            r_cnt   <= GAP_LD;
            r_done  <= GAP_ONE;
            r_state <= ST_GAP;
          end else begin
            r_cnt <= r_cnt - HOLD_W'(1);
          end
        end
        ST_GAP: begin
          // done is registered, so it is raised one edge early
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_done <= (r_cnt == HOLD_W'(1));
            r_cnt  <= r_cnt - HOLD_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed self-checking bench for keypad_emulator.
// Bounce timing is checked when KEYPAD_EMU_BOUNCE_EN is defined.
module tb_keypad_emulator;

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int B = 64;
`else
  localparam int B = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] col;
  logic [3:0] row;
  logic       busy;
  logic       done;
  int         checks = 0;
  int         errors = 0;

  keypad_emulator_if #(.HOLD_W(24)) cmd_if ();

  keypad_emulator dut (
    .clk  (clk),
    .rst  (rst),
    .col  (col),
    .row  (row),
    .cmd  (cmd_if),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] k, input int h);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_key   = k;
    cmd_if.cmd_hold  = 24'(h);
    @(posedge clk);
    #1 cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cmd_if.cmd_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 32'(cmd_if.cmd_ready), 32'd1);
  endtask

  task automatic run_cmd(
    input  logic [3:0] k,
    input  int h, input int n,
    input  int wlo, input int whi,
    input  logic [3:0] wrow,
    output int lo_cnt, output int lo_first,
    output int lo_last, output int dn_idx,
    output int dn_cnt, output int rdy_idx,
    output int win, output int tog);
    logic [3:0] prev;
    lo_cnt = 0; lo_first = -1; lo_last = -1;
    dn_idx = -1; dn_cnt = 0; rdy_idx = -1;
    win = 0; tog = 0; prev = 4'hF;
    send(k, h);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (row !== 4'hF) begin
        lo_cnt++;
        if (lo_first < 0) lo_first = i;
        lo_last = i;
      end
      if (i >= wlo && i <= whi && row === wrow) win++;
      if (i <= 64 && row !== prev) tog++;
      prev = row;
      if (done === 1'b1) begin
        dn_cnt++;
        if (dn_idx < 0) dn_idx = i;
      end
      if (cmd_if.cmd_ready === 1'b1 && rdy_idx < 0)
        rdy_idx = i;
    end
  endtask

  initial begin
    int lc, lf, ll, di, dc, ri, wn, tg, rkey, dcount;
    logic [3:0] colp [4];
    int keymap [4][4];
    colp = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    keymap = '{'{1, 2, 3, 12}, '{4, 5, 6, 13},
               '{7, 8, 9, 14}, '{11, 0, 10, 15}};
    rst = 1'b1;
    col = 4'b0000;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_key   = '0;
    cmd_if.cmd_hold  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_row", 32'(row), 32'hF);
    chk("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_row", 32'(row), 32'hF);

`ifndef KEYPAD_EMU_BOUNCE_EN
    col = 4'b1011;
    run_cmd(4'd5, 10, 30, 1, 10, 4'b1011,
            lc, lf, ll, di, dc, ri, wn, tg);
    chk("k5_low_cnt", 32'(lc), 32'd10);
    chk("k5_first", 32'(lf), 32'd1);
    chk("k5_last", 32'(ll), 32'd10);
    chk("k5_rowval", 32'(wn), 32'd10);
    chk("k5_done_at", 32'(di), 32'd26);
    chk("k5_done_cnt", 32'(dc), 32'd1);
    chk("k5_ready_at", 32'(ri), 32'd27);

    run_cmd(4'd5, 0, 20, 1, 1, 4'b1011,
            lc, lf, ll, di, dc, ri, wn, tg);
    chk("h0_low_cnt", 32'(lc), 32'd1);
    chk("h0_rowval", 32'(wn), 32'd1);
    chk("h0_done_at", 32'(di), 32'd17);
    chk("h0_ready_at", 32'(ri), 32'd18);
`else
    col = 4'b1101;
    run_cmd(4'd9, 20, 170, 65, 84, 4'b1101,
            lc, lf, ll, di, dc, ri, wn, tg);
    chk("b9_toggles", 32'(tg >= 2), 32'd1);
    chk("b9_steady", 32'(wn), 32'd20);
    chk("b9_done_at", 32'(di), 32'd164);
    chk("b9_done_cnt", 32'(dc), 32'd1);
    chk("b9_ready_at", 32'(ri), 32'd165);
`endif

    send(4'd5, 100);
    repeat (B + 2) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      col = colp[j % 4];
      #1;
      chk("k5_colscan", 32'(row),
          32'((j % 4 == 1) ? 4'b1011 : 4'b1111));
    end
    col = 4'b0000;
    wait_idle();

    send(4'd10, 50);
    repeat (B + 2) @(negedge clk);
    rkey = -1;
    for (int c = 0; c < 4; c++) begin
      col = ~(4'b1000 >> c);
      #1;
      for (int r = 0; r < 4; r++)
        if (row[3-r] === 1'b0) rkey = keymap[r][c];
    end
    chk("scan_hash", 32'(rkey), 32'd10);
    wait_idle();

    send(4'd11, 50);
    repeat (B + 2) @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      col = colp[c];
      #1;
      chk("star_col", 32'(row),
          32'((c == 0) ? 4'b1110 : 4'b1111));
    end
    wait_idle();

    col = 4'b1011;
    dcount = 0;
    send(4'd2, 5);
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 1)
        chk("busy_ready", 32'(cmd_if.cmd_ready), 32'd0);
      if (i == 1)
        chk("busy_flag", 32'(busy), 32'd1);
      if (done === 1'b1) dcount++;
      cmd_if.cmd_valid = (i <= 10);
      cmd_if.cmd_key   = 4'd3;
      cmd_if.cmd_hold  = 24'd5;
    end
    cmd_if.cmd_valid = 1'b0;
    chk("drop_done_cnt", 32'(dcount), 32'd1);
    chk("drop_idle", 32'(busy), 32'd0);

    col = 4'b0111;
    send(4'd1, 50);
    repeat (B + 3) @(negedge clk);
    chk("k1_pressed", 32'(row), 32'(4'b0111));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_row", 32'(row), 32'hF);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("mid_rst_nodone", 32'(dcount), 32'd0);
    chk("mid_rst_ready", 32'(cmd_if.cmd_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
